// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
// Holds the dm_type access encodings and the FSM state encoding.
package dm_access_unit_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the data-memory bus: store byte enables and replicated
// store data, load lane select with sign/zero extension, and alignment check.
module dm_lane_align
  import dm_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_type,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (addr_lo)
      2'd0:    byte_lane = rword[7:0];
      2'd1:    byte_lane = rword[15:8];
      2'd2:    byte_lane = rword[23:16];
      default: byte_lane = rword[31:24];
    endcase
  end

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rword;
    misalign   = (addr_lo != 2'b00);
    case (dm_type)
      DM_HALF, DM_HALF_U: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
        rdata_ext  = (dm_type == DM_HALF) ? {{16{half_lane[15]}}, half_lane}
                                          : {16'h0000, half_lane};
      end
      DM_BYTE, DM_BYTE_U: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        misalign   = 1'b0;
        rdata_ext  = (dm_type == DM_BYTE) ? {{24{byte_lane[7]}}, byte_lane}
                                          : {24'h000000, byte_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: latches one load/store, runs the bus
// request/ready handshake with a timeout, and stalls the pipeline until done.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  lane_addr_lo;
  logic [2:0]  lane_type;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misalign;

  // One aligner serves both directions: live inputs in IDLE for the store side
  // and alignment check, latched low address bits and type in BUSY for loads.
  always_comb begin
    lane_addr_lo = (state_q == ST_BUSY) ? addr_q[1:0] : addr[1:0];
    lane_type    = (state_q == ST_BUSY) ? type_q      : dm_type;
  end

  dm_lane_align u_lane (
    .addr_lo    (lane_addr_lo),
    .dm_type    (lane_type),
    .wdata      (wdata),
    .rword      (bus_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misalign   (lane_misalign)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    type_d   = type_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    bus_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!reset && (mem_r || mem_w)) begin
          if (lane_misalign) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_BUSY;
            cnt_d   = '0;
            addr_d  = addr;
            wdata_d = lane_wdata;
            be_d    = lane_be;
            we_d    = mem_w;
            type_d  = dm_type;
          end
        end
      end
      ST_BUSY: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        if (bus_ready) begin
          rdata_d = we_q ? '0 : lane_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          bus_err = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      type_q  <= DM_WORD;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      type_q  <= type_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata     = misalign ? '0 : rdata_q;
    bus_we    = bus_req & we_q;
    bus_be    = be_q;
    bus_addr  = {addr_q[31:2], 2'b00};
    bus_wdata = wdata_q;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Sits between the CPU MEM stage (EX/MEM outputs: address, store data, write enable, dmType) and a word-wide data memory bus with variable response latency.
- Generates byte enables and lane-aligned store data, sign/zero-extends loads, and detects misaligned accesses.
- Runs a request/ready handshake and drives a stall back to the pipeline until the access completes.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without bus_ready before the unit aborts with bus_err. Legal range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_r  in  1  MEM-stage load request
- mem_w  in  1  MEM-stage store request; mem_r and mem_w are never both 1
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data, right-justified
- dm_type  in  3  access width and signedness
- rdata  out  32  extended load result; valid while stall=0 in the DONE cycle
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on timeout
- bus_req  out  1  memory request
- bus_we  out  1  write strobe, qualified by bus_req
- bus_be  out  4  byte enables
- bus_addr  out  32  word address; bits [1:0] are 0
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  memory read word
- bus_ready  in  1  completion; sampled only while bus_req=1

Behaviour:
- dm_type encoding:
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101..111 treated as word.
- Byte enables:
  - Byte: bus_be = 1 << addr[1:0].
  - Half: bus_be = addr[1] ? 1100 : 0011.
  - Word: bus_be = 1111.
- Store data:
  - Byte: bus_wdata = {4{wdata[7:0]}}.
  - Half: bus_wdata = {2{wdata[15:0]}}.
  - Word: bus_wdata = wdata.
- Loads:
  - Select the lane from addr[1:0], then sign- or zero-extend per dm_type.
  - Captured into the rdata register on the cycle bus_ready=1.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠00.
  - No bus access; misalign=1 for that one cycle; stall=0; rdata=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - Valid access (mem_r|mem_w, aligned): latch addr/be/wdata/we/dm_type; stall=1 combinationally; go to BUSY.
    - Otherwise stay in IDLE with stall=0.
  - BUSY:
    - bus_req=1; bus outputs are held from the latched registers and stay stable.
    - stall=1; timeout counter increments each cycle.
    - bus_ready=1: capture the extended load data (stores capture 0); go to DONE.
    - Counter reaches TIMEOUT-1 with no ready: bus_err pulse; rdata=0; go to DONE.
  - DONE:
    - stall=0; bus_req=0; the pipeline advances this cycle.
    - The access still visible on the inputs is not restarted.
    - Go to IDLE.
- Latency: a zero-wait memory (ready in the first BUSY cycle) gives 2 stall cycles. Each extra wait cycle adds 1.
- Back-to-back accesses: DONE → IDLE → the next access starts in IDLE. There is no overlap.
- Reset:
  - State=IDLE; counter=0; rdata=0.
  - stall, misalign, bus_err, bus_req, bus_we = 0; bus_be=0000; bus_addr=0; bus_wdata=0.
  - Reset asserted while in BUSY drops bus_req on the next edge. A late bus_ready is ignored.
- bus_ready outside BUSY is ignored.
- Input changes during BUSY are ignored because the request is latched.

Decomposition:
- Shared package/include (alongside the existing ctrl encode definitions):
  - dm_type constants: DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U.
  - FSM state encoding: 2 bits.
- One combinational sub-module, dm_lane_align:
  - Store side: bus_be and bus_wdata.
  - Load side: lane select and extension, plus the misalign flag.
- The top holds the FSM, the timeout counter and the latch registers.

Test Plan:
- sw addr=0x10, wdata=0xDEADBEEF, ready on the 1st BUSY cycle → bus_addr=0x10, bus_be=1111, bus_we=1; stall high exactly 2 cycles.
- sb addr=0x13, wdata=0x000000A5 → bus_be=1000, bus_wdata=0xA5A5A5A5. sh addr=0x12, wdata=0x1234 → bus_be=1100, bus_wdata=0x12341234.
- lb addr=0x21, bus_rdata=0x0000_8000 (byte1=0x80) with 3 wait cycles → stall held 5 cycles; rdata=0xFFFFFF80. Same access with lbu → rdata=0x00000080.
- lh addr=0x22, bus_rdata=0xF00D_0000 → rdata=0xFFFFF00D. lhu → 0x0000F00D.
- lw addr=0x06 → misalign pulse 1 cycle; bus_req stays 0; stall 0. lh addr=0x05 → same response.
- TIMEOUT=16 with bus_ready held 0 → bus_err pulses on BUSY cycle 16, then DONE with rdata=0. Separately, assert reset in BUSY cycle 2 → bus_req=0 and stall=0 next cycle; a late bus_ready has no effect.
